// File: rtl/uart_rx_ctrl.sv
// UART receiver sequencing controller: start detection, oversampling/bit counters,
// one-cycle check/shift enables and frame-valid generation.
module uart_rx_ctrl #(
    parameter int PRESCALE_W = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic                  dat_samp_en,
    output logic                  strt_chk_en,
    output logic                  deser_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  data_valid,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [PRESCALE_W-1:0] ONE          = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] THREE        = PRESCALE_W'(3);
    localparam logic [PRESCALE_W-1:0] MIN_PRESCALE = PRESCALE_W'(8);
    localparam logic [3:0]            LAST_DATA    = 4'(DATA_WIDTH);

    state_t                state;
    logic [PRESCALE_W-1:0] prescale_q;
    logic                  par_en_q;
    logic                  err_flag;

    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] chk_prep;
    logic [PRESCALE_W-1:0] chk_eval;
    logic [PRESCALE_W-1:0] last_tick;
    logic                  wrap;

    // Enables are registered one tick early (H+1) so they are high exactly while edge_cnt == H+2.
    assign half      = {1'b0, prescale_q[PRESCALE_W-1:1]};
    assign chk_prep  = half + ONE;
    assign chk_eval  = half + THREE;
    assign last_tick = prescale_q - ONE;
    assign wrap      = (edge_cnt == last_tick);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            edge_cnt    <= '0;
            bit_cnt     <= '0;
            prescale_q  <= '0;
            par_en_q    <= 1'b0;
            err_flag    <= 1'b0;
            dat_samp_en <= 1'b0;
            strt_chk_en <= 1'b0;
            deser_en    <= 1'b0;
            par_chk_en  <= 1'b0;
            stp_chk_en  <= 1'b0;
            data_valid  <= 1'b0;
        end else begin
            strt_chk_en <= 1'b0;
            deser_en    <= 1'b0;
            par_chk_en  <= 1'b0;
            stp_chk_en  <= 1'b0;
            data_valid  <= 1'b0;

            if (state != IDLE) begin
                if (wrap) begin
                    edge_cnt <= '0;
                    bit_cnt  <= bit_cnt + 4'd1;
                end else begin
                    edge_cnt <= edge_cnt + ONE;
                end
            end

            case (state)
                IDLE: begin
                    edge_cnt <= '0;
                    bit_cnt  <= '0;
                    err_flag <= 1'b0;
                    if (!RX_IN && (Prescale >= MIN_PRESCALE)) begin
                        state       <= START;
                        prescale_q  <= Prescale;
                        par_en_q    <= PAR_EN;
                        dat_samp_en <= 1'b1;
                    end
                end
                START: begin
                    strt_chk_en <= (edge_cnt == chk_prep);
                    // A glitch abort takes priority over the end-of-bit wrap when they coincide.
                    if ((edge_cnt == chk_eval) && strt_glitch) begin
                        state       <= IDLE;
                        dat_samp_en <= 1'b0;
                        edge_cnt    <= '0;
                        bit_cnt     <= '0;
                    end else if (wrap) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    deser_en <= (edge_cnt == chk_prep);
                    if (wrap && (bit_cnt == LAST_DATA)) begin
                        state <= par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    par_chk_en <= (edge_cnt == chk_prep);
                    if (edge_cnt == chk_eval) begin
                        err_flag <= err_flag | par_err;
                    end
                    if (wrap) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    stp_chk_en <= (edge_cnt == chk_prep);
                    // Leave mid-stop-bit so a start edge right after the stop bit is caught.
                    if (edge_cnt == chk_eval) begin
                        data_valid  <= ~(err_flag | stp_err);
                        state       <= IDLE;
                        dat_samp_en <= 1'b0;
                        edge_cnt    <= '0;
                        bit_cnt     <= '0;
                        err_flag    <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: per-cycle comparison against a frame-timing model plus
// literal timing expectations for each directed scenario.
module tb_uart_rx_ctrl;

    localparam int PW = 6;
    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RX_IN = 1'b1;
    logic          PAR_EN = 1'b0;
    logic [PW-1:0] Prescale = 6'd8;
    logic          strt_glitch = 1'b0;
    logic          par_err = 1'b0;
    logic          stp_err = 1'b0;
    logic          dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid;
    logic [PW-1:0] edge_cnt;
    logic [3:0]    bit_cnt;

    uart_rx_ctrl #(.PRESCALE_W(PW), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
        .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
        .dat_samp_en(dat_samp_en), .strt_chk_en(strt_chk_en), .deser_en(deser_en),
        .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .data_valid(data_valid),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int t0;
        int p;
        bit par;
        bit glitch;
        bit pe;
        bit se;
        int abort;
    } frame_t;

    frame_t frames[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     cur_t0 = 0;
    bit     gv = 1'b0, pv = 1'b0, sv = 1'b0;

    int deser_n, deser_first, deser_last, strt_cyc, stp_cyc, stp_bit, par_n, par_bit;
    int dv_q[$];

    initial forever begin
        @(posedge CLK);
        cyc = cyc + 1;
    end

    function automatic logic [15:0] outs();
        return {dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid,
                edge_cnt, bit_cnt};
    endfunction

    // Expected outputs after clock edge c, from each frame's start time and bit layout.
    function automatic logic [15:0] model(int c);
        logic [15:0] e;
        int k, p, h, nb, kend, b, t;
        bit ok;
        e = '0;
        foreach (frames[i]) begin
            if (c >= frames[i].abort) continue;
            k    = c - frames[i].t0;
            p    = frames[i].p;
            h    = p / 2;
            nb   = DW + 2 + (frames[i].par ? 1 : 0);
            kend = frames[i].glitch ? h + 4 : (nb - 1) * p + h + 4;
            ok   = !frames[i].glitch && !(frames[i].par && frames[i].pe) && !frames[i].se;
            if (k >= 0 && k < kend) begin
                b = k / p;
                t = k % p;
                e[15]  = 1'b1;
                e[14]  = (k == h + 2);
                e[13]  = (b >= 1) && (b <= DW) && (t == h + 2);
                e[12]  = frames[i].par && (b == DW + 1) && (t == h + 2);
                e[11]  = (b == nb - 1) && (t == h + 2);
                e[9:4] = 6'(t);
                e[3:0] = 4'(b);
            end else if (k == kend) begin
                e[10] = ok;
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic clear_mon();
        deser_n = 0; deser_first = -1; deser_last = -1; strt_cyc = -1;
        stp_cyc = -1; stp_bit = -1; par_n = 0; par_bit = -1;
        dv_q.delete();
    endtask

    // Per-cycle compare and event monitor.
    initial forever begin
        logic [15:0] act, req;
        @(posedge CLK);
        #1;
        act = outs();
        req = model(cyc);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL outputs cyc=%0d actual=%h required=%h", cyc, act, req);
        end
        if (deser_en) begin
            deser_n++;
            if (deser_first < 0) deser_first = cyc;
            deser_last = cyc;
        end
        if (strt_chk_en && strt_cyc < 0) strt_cyc = cyc;
        if (stp_chk_en) begin stp_cyc = cyc; stp_bit = int'(bit_cnt); end
        if (par_chk_en) begin par_n++; par_bit = int'(bit_cnt); end
        if (data_valid) dv_q.push_back(cyc);
    end

    // Check-block emulation: registered result appears the cycle after its enable.
    initial forever begin
        logic s, p, t;
        @(negedge CLK);
        if (strt_chk_en || par_chk_en || stp_chk_en) begin
            s = strt_chk_en; p = par_chk_en; t = stp_chk_en;
            @(posedge CLK);
            #1;
            if (s) strt_glitch = gv;
            if (p) par_err = pv;
            if (t) stp_err = sv;
        end
    end

    task automatic gap(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Called 1 time unit after a rising edge; the start bit is first sampled at the next edge.
    task automatic send_frame(input int p, input logic [7:0] d, input bit par,
                              input bit pe, input bit se, input int nsend);
        logic [11:0] bits;
        int nb;
        nb = DW + 2 + (par ? 1 : 0);
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) bits[1+i] = d[i];
        if (par) bits[DW+1] = ^d;
        Prescale = PW'(p);
        PAR_EN = par;
        gv = 1'b0; pv = pe; sv = se;
        cur_t0 = cyc + 1;
        frames.push_back('{cur_t0, p, par, 1'b0, pe, se, 32'h3fff_ffff});
        for (int j = 0; j < nsend && j < nb; j++) begin
            RX_IN = bits[j];
            repeat (p) @(posedge CLK);
            #1;
        end
        RX_IN = 1'b1;
    endtask

    initial begin
        clear_mon();
        repeat (3) @(posedge CLK);
        #2;
        chk("reset_state", int'(outs()), 0);
        @(negedge CLK);
        RST = 1'b1;
        gap(3);

        // Clean frame, Prescale 8, no parity
        clear_mon();
        send_frame(8, 8'hA5, 1'b0, 1'b0, 1'b0, 10);
        gap(4);
        chk("clean_deser_n", deser_n, 8);
        chk("clean_deser_first", deser_first - cur_t0, 14);
        chk("clean_deser_last", deser_last - cur_t0, 70);
        chk("clean_stp_edge", stp_cyc - cur_t0, 78);
        chk("clean_dv_n", dv_q.size(), 1);
        chk("clean_dv_edge", (dv_q.size() > 0) ? dv_q[0] - cur_t0 : -1, 80);

        // Start glitch
        clear_mon();
        Prescale = 6'd8; PAR_EN = 1'b0; gv = 1'b1;
        cur_t0 = cyc + 1;
        frames.push_back('{cur_t0, 8, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3fff_ffff});
        RX_IN = 1'b0;
        gap(2);
        RX_IN = 1'b1;
        repeat (6) @(posedge CLK);
        #2;
        chk("glitch_active_e7", int'(dat_samp_en), 1);
        @(posedge CLK);
        #2;
        chk("glitch_idle_e8", int'(dat_samp_en), 0);
        gap(12);
        gv = 1'b0;
        chk("glitch_strt_edge", strt_cyc - cur_t0, 6);
        chk("glitch_deser_n", deser_n, 0);
        chk("glitch_dv_n", dv_q.size(), 0);

        // Parity error, Prescale 16
        clear_mon();
        send_frame(16, 8'h3B, 1'b1, 1'b1, 1'b0, 11);
        gap(4);
        chk("perr_par_bit", par_bit, 9);
        chk("perr_stp_bit", stp_bit, 10);
        chk("perr_dv_n", dv_q.size(), 0);
        chk("perr_idle", int'(dat_samp_en), 0);
        clear_mon();
        send_frame(16, 8'h3B, 1'b1, 1'b0, 1'b0, 11);
        gap(4);
        chk("par_ok_dv_n", dv_q.size(), 1);
        chk("par_ok_par_n", par_n, 1);
        chk("par_ok_dv_edge", (dv_q.size() > 0) ? dv_q[0] - cur_t0 : -1, 172);

        // Stop error then clean frame
        clear_mon();
        send_frame(8, 8'h0F, 1'b0, 1'b0, 1'b1, 10);
        gap(4);
        chk("serr_dv_n", dv_q.size(), 0);
        clear_mon();
        send_frame(8, 8'hF0, 1'b0, 1'b0, 1'b0, 10);
        gap(4);
        chk("serr_next_dv_n", dv_q.size(), 1);

        // Back-to-back frames, Prescale 32
        clear_mon();
        send_frame(32, 8'h3C, 1'b0, 1'b0, 1'b0, 10);
        send_frame(32, 8'hC3, 1'b0, 1'b0, 1'b0, 10);
        gap(4);
        chk("b2b_dv_n", dv_q.size(), 2);
        chk("b2b_dv_spacing", (dv_q.size() > 1) ? dv_q[1] - dv_q[0] : -1, 320);
        chk("b2b_deser_n", deser_n, 16);

        // Reset in the middle of DATA
        clear_mon();
        send_frame(8, 8'h5A, 1'b0, 1'b0, 1'b0, 4);
        repeat (3) @(posedge CLK);
        #2;
        chk("rst_pre_bit_cnt", int'(bit_cnt), 4);
        #1;
        frames[frames.size()-1].abort = cyc + 1;
        RST = 1'b0;
        #1;
        chk("rst_mid_outputs", int'(outs()), 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        gap(3);
        chk("rst_dv_n", dv_q.size(), 0);
        clear_mon();
        send_frame(8, 8'h81, 1'b0, 1'b0, 1'b0, 10);
        gap(4);
        chk("rst_fresh_dv_n", dv_q.size(), 1);
        chk("rst_fresh_deser_n", deser_n, 8);

        // Config change mid-frame is ignored
        clear_mon();
        fork
            send_frame(8, 8'h66, 1'b0, 1'b0, 1'b0, 10);
            begin
                repeat (30) @(posedge CLK);
                #2;
                PAR_EN = 1'b1;
                Prescale = 6'd16;
            end
        join
        gap(4);
        chk("cfg_par_n", par_n, 0);
        chk("cfg_stp_edge", stp_cyc - cur_t0, 78);
        chk("cfg_dv_n", dv_q.size(), 1);
        PAR_EN = 1'b0;
        Prescale = 6'd8;
        gap(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Sequencing controller for the UART receiver datapath.
- Detects the start edge on RX_IN and runs the oversampling edge counter and the frame bit counter.
- Issues one-cycle enables to the start-check, data-deserializer, parity-check and stop-check blocks, then evaluates their error flags.
- Asserts data_valid for each clean frame. Sits between the RX pin synchronizer and the sampler/checker/deserializer blocks.

Parameters:
- PRESCALE_W, 6, width of the Prescale input and the edge counter.
- DATA_WIDTH, 8, data bits per frame, LSB first.

Ports:
- CLK  input  1  oversampling clock.
- RST  input  1  asynchronous, active-low reset.
- RX_IN  input  1  synchronized serial line; idle high.
- PAR_EN  input  1  parity bit present in the frame.
- Prescale  input  PRESCALE_W  oversampling ratio; supported values 8, 16, 32.
- strt_glitch  input  1  registered start-check result; valid the cycle after strt_chk_en.
- par_err  input  1  registered parity-check result; valid the cycle after par_chk_en.
- stp_err  input  1  registered stop-check result; valid the cycle after stp_chk_en.
- dat_samp_en  output  1  enables the majority sampler.
- strt_chk_en  output  1  one-cycle start-check enable.
- deser_en  output  1  one-cycle shift enable per data bit.
- par_chk_en  output  1  one-cycle parity-check enable.
- stp_chk_en  output  1  one-cycle stop-check enable.
- data_valid  output  1  one-cycle pulse per error-free frame.
- edge_cnt  output  PRESCALE_W  oversampling tick within the current bit.
- bit_cnt  output  4  frame bit index. 0 = start bit; 1..DATA_WIDTH = data bits; next index = parity bit if present; last index = stop bit.

Behaviour:
- Reset: all outputs 0, state IDLE, error flag cleared, latched config cleared. Reset is honoured in every state, including mid-frame.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- Define H = Prescale/2. The external sampler takes its samples at edge_cnt H-1, H and H+1, so the sampled bit is ready at H+2.
- Config latch: Prescale and PAR_EN are latched on the IDLE->START transition. Changes to either mid-frame are ignored.
- Prescale < 8: the block stays in IDLE and ignores RX_IN.
- Counting: in any state other than IDLE, edge_cnt increments every cycle. When edge_cnt == Prescale-1 it wraps to 0 and bit_cnt increments. In IDLE both counters are held at 0.
- dat_samp_en = 1 in every state except IDLE.
- IDLE: RX_IN == 0 at a clock edge -> START, with edge_cnt = 0 and bit_cnt = 0.
- START:
  - strt_chk_en = 1 while edge_cnt == H+2.
  - At edge_cnt == H+3: if strt_glitch = 1 -> IDLE, counters cleared; otherwise stay in START.
  - On wrap -> DATA, bit_cnt = 1.
- DATA:
  - deser_en = 1 while edge_cnt == H+2, once per data bit, DATA_WIDTH pulses total.
  - On wrap with bit_cnt == DATA_WIDTH -> PARITY if the latched PAR_EN = 1, else STOP.
- PARITY:
  - par_chk_en = 1 at edge_cnt == H+2.
  - At H+3, par_err is ORed into the error flag.
  - On wrap -> STOP.
- STOP:
  - stp_chk_en = 1 at edge_cnt == H+2.
  - At H+3: data_valid <= ~(error flag | stp_err), registered, high for exactly one cycle.
  - Same edge: state -> IDLE, counters and error flag cleared.
  - Leaving STOP mid-stop-bit lets a start edge immediately after the stop bit be caught, so back-to-back frames are supported.
- Simultaneous events: reset dominates everything. A falling RX_IN while in STOP before H+3 is ignored.
- At most one of strt_chk_en / deser_en / par_chk_en / stp_chk_en is high in any cycle.

Test Plan:
- Clean frame: Prescale=8, PAR_EN=0, frame 0xA5, RX_IN first sampled low at edge 0.
  - Required: exactly 8 deser_en pulses, at edges 14, 22, …, 70.
  - Required: stp_chk_en at edge 78; data_valid high only between edges 80 and 81; IDLE after edge 80.
- Start glitch: Prescale=8, RX_IN low for 2 cycles then high; checker returns strt_glitch=1.
  - Required: strt_chk_en at edge 6; return to IDLE at edge 8.
  - Required: no deser_en and no data_valid.
- Parity error: Prescale=16, PAR_EN=1, par_err=1 returned after par_chk_en.
  - Required: bit_cnt reaches 9 in PARITY and 10 in STOP; no data_valid; IDLE after stop evaluation.
  - Rerun with par_err=0: exactly one data_valid pulse.
- Stop error: Prescale=8, PAR_EN=0, stp_err=1 → no data_valid; next frame with stp_err=0 → one data_valid pulse.
- Back-to-back: Prescale=32, two frames 0x3C and 0xC3 with no idle gap.
  - Required: two data_valid pulses, spaced 320 cycles apart.
  - Required: 16 deser_en pulses in total.
- Reset mid-frame: assert RST at bit_cnt=4 in DATA.
  - Required: all outputs 0 immediately; edge_cnt=0, bit_cnt=0.
  - Required: after release, a fresh frame completes normally.
- Mid-frame config change: toggle PAR_EN mid-frame → frame format unchanged (no PARITY state entered).
